// File: rtl/framebuffer_writer.sv
// Write-side engine for the frame memory port A: single-pixel writes and
// clipped rectangle fills, one memory write per clock, row-major addressing.
module framebuffer_writer #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_fill,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [PIX_W-1:0]  cmd_color,
  output logic [ADDR_W-1:0] address_a_sig,
  output logic [PIX_W-1:0]  data_a_sig,
  output logic              wren_a_sig,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [9:0]        W10 = 10'(IMG_W);
  localparam logic [8:0]        H9  = 9'(IMG_H);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {IDLE, FILL, FDONE} state_t;

  state_t      state;
  logic [9:0]  wc_r;
  logic [8:0]  hc_r;
  logic [9:0]  col;
  logic [8:0]  row;

  function automatic logic [9:0] clip_w(input logic [9:0] req, input logic [9:0] room);
    return (req < room) ? req : room;
  endfunction

  function automatic logic [8:0] clip_h(input logic [8:0] req, input logic [8:0] room);
    return (req < room) ? req : room;
  endfunction

  logic              in_range;
  logic [9:0]        wc;
  logic [8:0]        hc;
  logic [ADDR_W-1:0] start_addr;
  logic              last_col;
  logic              last_row;

  // Room values wrap for out-of-range origins, but those commands are rejected.
  assign in_range   = (cmd_x < W10) && (cmd_y < H9);
  assign wc         = clip_w(cmd_w, W10 - cmd_x);
  assign hc         = clip_h(cmd_h, H9 - cmd_y);
  assign start_addr = ADDR_W'(cmd_y) * W_A + ADDR_W'(cmd_x);
  assign last_col   = (col == wc_r - 10'd1);
  assign last_row   = (row == hc_r - 9'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      wren_a_sig    <= 1'b0;
      address_a_sig <= '0;
      data_a_sig    <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      wren_a_sig <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (!in_range) begin
              err <= 1'b1;
            end else if (!cmd_fill) begin
              wren_a_sig    <= 1'b1;
              address_a_sig <= start_addr;
              data_a_sig    <= cmd_color;
              done          <= 1'b1;
            end else if (wc == 10'd0 || hc == 9'd0) begin
              done <= 1'b1;
            end else begin
              state         <= FILL;
              cmd_ready     <= 1'b0;
              busy          <= 1'b1;
              wren_a_sig    <= 1'b1;
              address_a_sig <= start_addr;
              data_a_sig    <= cmd_color;
              wc_r          <= wc;
              hc_r          <= hc;
              col           <= 10'd0;
              row           <= 9'd0;
              done          <= (wc == 10'd1) && (hc == 9'd1);
            end
          end
        end
        FILL: begin
          // Outputs show the current pixel; this edge advances to the next one.
          if (last_col && last_row) begin
            state <= FDONE;
            busy  <= 1'b0;
          end else if (last_col) begin
            wren_a_sig    <= 1'b1;
            col           <= 10'd0;
            row           <= row + 9'd1;
            address_a_sig <= address_a_sig + W_A - ADDR_W'(wc_r) + ADDR_W'(1);
            done          <= (wc_r == 10'd1) && (row + 9'd1 == hc_r - 9'd1);
          end else begin
            wren_a_sig    <= 1'b1;
            col           <= col + 10'd1;
            address_a_sig <= address_a_sig + ADDR_W'(1);
            done          <= last_row && (col + 10'd1 == wc_r - 10'd1);
          end
        end
        FDONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: vector table, directed sequences and random
// commands checked against a per-command list of expected frame writes.
module tb_framebuffer_writer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_fill;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic [18:0] address_a_sig;
  logic [7:0]  data_a_sig;
  logic        wren_a_sig;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  framebuffer_writer #(.IMG_W(640), .IMG_H(480), .ADDR_W(19), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill(cmd_fill), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .address_a_sig(address_a_sig), .data_a_sig(data_a_sig),
    .wren_a_sig(wren_a_sig), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit   fill;
    int   x, y, w, h, color;
    bit   e_wren;
    int   e_addr, e_data;
    bit   e_done, e_err;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(input bit fill, input int x, input int y, input int w,
                              input int h, input int color, input bit e_wren,
                              input int e_addr, input int e_data, input bit e_done,
                              input bit e_err);
    vec_t v;
    v.fill = fill; v.x = x; v.y = y; v.w = w; v.h = h; v.color = color;
    v.e_wren = e_wren; v.e_addr = e_addr; v.e_data = e_data;
    v.e_done = e_done; v.e_err = e_err;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fill, input int x, input int y, input int w, input int h,
                       input int color);
    cmd_valid = 1'b1;
    cmd_fill  = fill;
    cmd_x     = 10'(x);
    cmd_y     = 9'(y);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_color = 8'(color);
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    cmd_fill  = 1'($urandom);
    cmd_x     = 10'($urandom);
    cmd_y     = 9'($urandom);
    cmd_w     = 10'($urandom);
    cmd_h     = 9'($urandom);
    cmd_color = 8'($urandom);
  endtask

  // Issue one command from idle and check every cycle until the engine is idle again.
  task automatic run_cmd(input string tag, input bit fill, input int x, input int y,
                         input int w, input int h, input int color);
    int  wc, hc, n;
    bit  inr;
    int  exp_q[$];
    inr = (x < 640) && (y < 480);
    if (inr && fill) begin
      wc = (w < 640 - x) ? w : 640 - x;
      hc = (h < 480 - y) ? h : 480 - y;
    end else if (inr) begin
      wc = 1; hc = 1;
    end else begin
      wc = 0; hc = 0;
    end
    for (int r = 0; r < hc; r++)
      for (int c = 0; c < wc; c++)
        exp_q.push_back((y + r) * 640 + x + c);
    n = exp_q.size();

    check({tag, "_ready_pre"}, 64'(cmd_ready), 64'd1);
    drive(fill, x, y, w, h, color);
    step();
    scramble();
    if (!inr) begin
      check({tag, "_err"}, {err, wren_a_sig, done, busy, cmd_ready}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      step();
      check({tag, "_err_after"}, {err, wren_a_sig}, 2'b00);
    end else if (n == 0) begin
      check({tag, "_empty"}, {err, wren_a_sig, done, busy, cmd_ready}, {1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      step();
      check({tag, "_empty_after"}, {wren_a_sig, done}, 2'b00);
    end else begin
      for (int k = 0; k < n; k++) begin
        if (k > 0) step();
        check({tag, "_wr"},
              {wren_a_sig, address_a_sig, data_a_sig, done, busy, cmd_ready, err},
              {1'b1, 19'(exp_q[k]), 8'(color), (k == n - 1), fill, !fill, 1'b0});
      end
      step();
      if (fill) begin
        check({tag, "_fdone"}, {wren_a_sig, busy, cmd_ready, done}, 4'b0000);
        step();
        check({tag, "_idle"}, {wren_a_sig, busy, cmd_ready, done}, 4'b0010);
      end else begin
        check({tag, "_px_after"}, {wren_a_sig, done, cmd_ready}, 3'b001);
      end
    end
  endtask

  initial begin
    int x, y, w, h;
    bit fl;

    tbl[0] = mk(0, 3, 2, 0, 0, 8'hAA, 1, 1283, 8'hAA, 1, 0);
    tbl[1] = mk(0, 640, 0, 0, 0, 8'h33, 0, 1283, 8'hAA, 0, 1);
    tbl[2] = mk(0, 0, 480, 0, 0, 8'h44, 0, 1283, 8'hAA, 0, 1);
    tbl[3] = mk(1, 5, 5, 0, 9, 8'h55, 0, 1283, 8'hAA, 1, 0);
    tbl[4] = mk(1, 700, 3, 5, 5, 8'h66, 0, 1283, 8'hAA, 0, 1);
    tbl[5] = mk(0, 639, 479, 0, 0, 8'h03, 1, 307199, 8'h03, 1, 0);
    tbl[6] = mk(1, 5, 5, 9, 0, 8'h77, 0, 307199, 8'h03, 1, 0);
    tbl[7] = mk(0, 0, 0, 0, 0, 8'h11, 1, 0, 8'h11, 1, 0);

    rst = 1'b1;
    scramble();
    step();
    step();
    check("reset_outputs",
          {cmd_ready, wren_a_sig, address_a_sig, data_a_sig, busy, done, err},
          {1'b1, 1'b0, 19'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_no_write", {wren_a_sig, done, err, cmd_ready}, 4'b0001);
    end

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].fill, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].color);
      step();
      scramble();
      check($sformatf("vec%0d", i),
            {wren_a_sig, address_a_sig, data_a_sig, done, err, busy, cmd_ready},
            {tbl[i].e_wren, 19'(tbl[i].e_addr), 8'(tbl[i].e_data), tbl[i].e_done,
             tbl[i].e_err, 1'b0, 1'b1});
      step();
      check($sformatf("vec%0d_after", i), {wren_a_sig, done, err}, 3'b000);
    end

    drive(0, 0, 0, 0, 0, 8'h01);
    step();
    check("b2b_0", {wren_a_sig, address_a_sig, data_a_sig, done, cmd_ready},
          {1'b1, 19'd0, 8'h01, 1'b1, 1'b1});
    drive(0, 639, 0, 0, 0, 8'h02);
    step();
    check("b2b_1", {wren_a_sig, address_a_sig, data_a_sig, done, cmd_ready},
          {1'b1, 19'd639, 8'h02, 1'b1, 1'b1});
    drive(0, 639, 479, 0, 0, 8'h03);
    step();
    check("b2b_2", {wren_a_sig, address_a_sig, data_a_sig, done, cmd_ready},
          {1'b1, 19'd307199, 8'h03, 1'b1, 1'b1});
    scramble();
    step();
    check("b2b_after", {wren_a_sig, done}, 2'b00);

    run_cmd("fill_basic", 1, 10, 1, 3, 2, 8'h5C);
    run_cmd("fill_clip", 1, 638, 479, 4, 2, 8'h1F);
    run_cmd("fill_zero_w", 1, 5, 5, 0, 9, 8'h20);
    run_cmd("fill_one", 1, 100, 100, 1, 1, 8'h21);
    run_cmd("fill_col", 1, 7, 470, 1, 20, 8'h22);
    run_cmd("pixel_err", 0, 640, 0, 0, 0, 8'h23);

    for (int i = 0; i < 40; i++) begin
      fl = 1'($urandom_range(0, 1));
      x  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(600, 660)) : int'($urandom_range(0, 639));
      y  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, 479));
      if ($urandom_range(0, 3) == 0) begin
        w = int'($urandom_range(0, 1023));
        h = int'($urandom_range(0, 2));
      end else begin
        w = int'($urandom_range(0, 12));
        h = int'($urandom_range(0, 12));
      end
      run_cmd($sformatf("rnd%0d", i), fl, x, y, w, h, int'($urandom_range(0, 255)));
    end

    drive(1, 0, 0, 100, 100, 8'h99);
    step();
    scramble();
    for (int k = 1; k < 5; k++) step();
    check("abort_5th_write", {wren_a_sig, address_a_sig, busy}, {1'b1, 19'd4, 1'b1});
    rst = 1'b1;
    step();
    check("abort_reset", {wren_a_sig, done, busy, cmd_ready}, 4'b0001);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_after", {wren_a_sig, done, busy, cmd_ready}, 4'b0001);
    end
    run_cmd("post_abort", 0, 1, 1, 0, 0, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
